ibex_lsu_pipelined: RTL and testbench

// - Next-gen load/store unit: sits between the EX stage and the data bus, with a parametrised bus width and up to
//   MAX_OUTSTANDING in-order bus transactions in flight.
// - Aligns bytes and halfwords, and sign/zero-extends them.
// - Splits accesses that cross a bus word into two beats (optional), and reports real bus errors per access.

---
 rtl/ibex_lsu_pipelined.sv | 228 ++++++++++++++++++++++
 tb/tb_ibex_lsu_pipelined.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_lsu_pipelined.sv
// Pipelined load/store unit: byte/halfword alignment, in-order tracking of outstanding bus beats.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats; otherwise they return an error.
module ibex_lsu_pipelined #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic                data_err_i,
  output logic [31:0]         data_addr_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic [DATA_W-1:0]   data_rdata_i,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [1:0]          lsu_type_i,
  input  logic                lsu_sign_ext_i,
  input  logic [31:0]         lsu_addr_i,
  input  logic [31:0]         lsu_wdata_i,
  output logic                lsu_ready_o,
  output logic                lsu_rvalid_o,
  output logic [31:0]         lsu_rdata_o,
  output logic                load_err_o,
  output logic                store_err_o,
  output logic                busy_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned SZ_W  = OFF_W + 2;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BEAT_SINGLE = 2'd0, BEAT_FIRST = 2'd1, BEAT_SECOND = 2'd2} beat_e;

  typedef struct packed {
    logic             we;
    logic [1:0]       ltype;
    logic [OFF_W-1:0] off;
    logic             sign;
    beat_e            beat;
  } trk_t;

  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_wr;
  logic [PTR_W-1:0]    r_rd;
  trk_t                r_fifo [MAX_OUTSTANDING];

  logic [OFF_W-1:0]    w_off;
  logic [SZ_W-1:0]     w_size;
  logic [3:0]          w_mask;
  logic                w_misal;
  logic [2*BE_W-1:0]   w_be_dbl;
  logic [DATA_W-1:0]   w_wd_ext;
  logic [2*DATA_W-1:0] w_wd_dbl;
  logic [31:0]         w_addr_base;
  logic                w_req;
  logic                w_ready;
  logic                w_second;
  logic                w_mis_err;
  beat_e               w_push_beat;
  logic                w_push;
  logic                w_pop;
  trk_t                w_entry;
  trk_t                w_top;
  logic [2*DATA_W-1:0] w_rd_dbl;
  logic [2*DATA_W-1:0] w_rd_shift;
  logic [31:0]         w_w32;
  logic [31:0]         w_ext;
  logic                w_err;
  logic                w_unused;

`ifdef LSU_MISALIGNED_EN
  typedef enum logic {ST_IDLE, ST_SECOND} state_e;
  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_stash;
  logic                r_err_q;
`endif

  // Request decode: size mask, lane rotation and misalignment detection
  always_comb begin
    case (lsu_type_i)
      2'b00:   begin w_size = SZ_W'(4); w_mask = 4'b1111; end
      2'b01:   begin w_size = SZ_W'(2); w_mask = 4'b0011; end
      default: begin w_size = SZ_W'(1); w_mask = 4'b0001; end
    endcase
  end

  assign w_off       = lsu_addr_i[OFF_W-1:0];
  assign w_misal     = (SZ_W'(w_off) + w_size) > SZ_W'(BE_W);
  assign w_be_dbl    = (2*BE_W)'(w_mask) << w_off;
  assign w_wd_ext    = DATA_W'(lsu_wdata_i);
  assign w_wd_dbl    = {w_wd_ext, w_wd_ext} << {w_off, 3'b000};
  assign w_addr_base = {lsu_addr_i[31:OFF_W], OFF_W'(0)};

  // Issue control
  always_comb begin
    w_req       = 1'b0;
    w_ready     = 1'b0;
    w_second    = 1'b0;
    w_mis_err   = 1'b0;
    w_push_beat = BEAT_SINGLE;
`ifdef LSU_MISALIGNED_EN
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (lsu_req_i && w_misal) begin
          w_req       = (r_cnt <= CNT_W'(MAX_OUTSTANDING - 2));
          w_push_beat = BEAT_FIRST;
          if (w_req && data_gnt_i) w_state_nxt = ST_SECOND;
        end else if (lsu_req_i) begin
          w_req   = (r_cnt < CNT_W'(MAX_OUTSTANDING));
          w_ready = w_req && data_gnt_i;
        end
      end
      ST_SECOND: begin
        w_req       = 1'b1;
        w_second    = 1'b1;
        w_push_beat = BEAT_SECOND;
        w_ready     = data_gnt_i;
        if (data_gnt_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
`else
    if (lsu_req_i && w_misal) begin
      w_mis_err = (r_cnt == '0);
      w_ready   = w_mis_err;
    end else if (lsu_req_i) begin
      w_req   = (r_cnt < CNT_W'(MAX_OUTSTANDING));
      w_ready = w_req && data_gnt_i;
    end
`endif
  end

  assign data_req_o   = w_req;
  assign data_we_o    = w_req & lsu_we_i;
  assign data_addr_o  = !w_req ? '0 : (w_second ? w_addr_base + 32'(BE_W) : w_addr_base);
  assign data_be_o    = !w_req ? '0 : (w_second ? w_be_dbl[2*BE_W-1:BE_W] : w_be_dbl[BE_W-1:0]);
  assign data_wdata_o = w_req ? w_wd_dbl[2*DATA_W-1:DATA_W] : '0;
  assign lsu_ready_o  = w_ready;
  assign busy_o       = (r_cnt != '0) | w_req;

  assign w_push      = w_req & data_gnt_i;
  assign w_pop       = data_rvalid_i & (r_cnt != '0);
  assign w_top       = r_fifo[r_rd];
  assign w_entry.we    = lsu_we_i;
  assign w_entry.ltype = lsu_type_i;
  assign w_entry.off   = w_off;
  assign w_entry.sign  = lsu_sign_ext_i;
  assign w_entry.beat  = w_push_beat;

  // Response path: join with the stashed first beat, shift down, extend
`ifdef LSU_MISALIGNED_EN
  assign w_rd_dbl = (w_top.beat == BEAT_SECOND) ? {data_rdata_i, r_stash} : {DATA_W'(0), data_rdata_i};
  assign w_err    = data_err_i | ((w_top.beat == BEAT_SECOND) & r_err_q);
`else
  assign w_rd_dbl = {DATA_W'(0), data_rdata_i};
  assign w_err    = data_err_i;
`endif
  assign w_rd_shift = w_rd_dbl >> {w_top.off, 3'b000};
  assign w_w32      = w_rd_shift[31:0];

  always_comb begin
    case (w_top.ltype)
      2'b00:   w_ext = w_w32;
      2'b01:   w_ext = {{16{w_top.sign & w_w32[15]}}, w_w32[15:0]};
      default: w_ext = {{24{w_top.sign & w_w32[7]}}, w_w32[7:0]};
    endcase
  end

  always_comb begin
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    load_err_o   = 1'b0;
    store_err_o  = 1'b0;
    if (w_pop && (w_top.beat != BEAT_FIRST)) begin
      lsu_rvalid_o = 1'b1;
      lsu_rdata_o  = w_top.we ? '0 : w_ext;
      load_err_o   = ~w_top.we & w_err;
      store_err_o  = w_top.we & w_err;
    end else if (w_mis_err) begin
      lsu_rvalid_o = 1'b1;
      load_err_o   = ~lsu_we_i;
      store_err_o  = lsu_we_i;
    end
  end

  // Tracking FIFO pointers/count and split-access state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
`ifdef LSU_MISALIGNED_EN
      r_state <= ST_IDLE;
      r_stash <= '0;
      r_err_q <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
`ifdef LSU_MISALIGNED_EN
      r_state <= w_state_nxt;
      if (w_pop && (w_top.beat == BEAT_FIRST)) begin
        r_stash <= data_rdata_i;
        r_err_q <= data_err_i;
      end else if (w_pop && (w_top.beat == BEAT_SECOND)) begin
        r_err_q <= 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= w_entry;
  end

  assign w_unused = ^{w_wd_dbl[DATA_W-1:0], w_rd_shift[2*DATA_W-1:32], w_be_dbl};

endmodule

// File: tb/tb_ibex_lsu_pipelined.sv
// Directed bench for ibex_lsu_pipelined: a 32-bit instance for the main vectors and
// corner sequences, a 64-bit instance for wide-bus lane placement.
module tb_ibex_lsu_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit bus instance
  logic        req32 = 0, we32 = 0, sx32 = 0, gnt32 = 0, rv32 = 0, er32 = 0;
  logic [1:0]  ty32 = 0;
  logic [31:0] addr32 = 0, wd32 = 0, rd32 = 0;
  logic        dreq32, dwe32, rdy32, lrv32, lerr32, serr32, busy32;
  logic [31:0] daddr32, dwd32, lrd32;
  logic [3:0]  dbe32;

  // 64-bit bus instance
  logic        req64 = 0, we64 = 0, sx64 = 0, gnt64 = 0, rv64 = 0, er64 = 0;
  logic [1:0]  ty64 = 0;
  logic [31:0] addr64 = 0, wd64 = 0;
  logic [63:0] rd64 = 0;
  logic        dreq64, dwe64, rdy64, lrv64, lerr64, serr64, busy64;
  logic [31:0] daddr64, lrd64;
  logic [63:0] dwd64;
  logic [7:0]  dbe64;

  ibex_lsu_pipelined #(.DATA_W(32), .MAX_OUTSTANDING(2)) u_dut32 (
    .clk(clk), .rst(rst),
    .data_req_o(dreq32), .data_gnt_i(gnt32), .data_rvalid_i(rv32), .data_err_i(er32),
    .data_addr_o(daddr32), .data_we_o(dwe32), .data_be_o(dbe32), .data_wdata_o(dwd32),
    .data_rdata_i(rd32),
    .lsu_req_i(req32), .lsu_we_i(we32), .lsu_type_i(ty32), .lsu_sign_ext_i(sx32),
    .lsu_addr_i(addr32), .lsu_wdata_i(wd32),
    .lsu_ready_o(rdy32), .lsu_rvalid_o(lrv32), .lsu_rdata_o(lrd32),
    .load_err_o(lerr32), .store_err_o(serr32), .busy_o(busy32)
  );

  ibex_lsu_pipelined #(.DATA_W(64), .MAX_OUTSTANDING(2)) u_dut64 (
    .clk(clk), .rst(rst),
    .data_req_o(dreq64), .data_gnt_i(gnt64), .data_rvalid_i(rv64), .data_err_i(er64),
    .data_addr_o(daddr64), .data_we_o(dwe64), .data_be_o(dbe64), .data_wdata_o(dwd64),
    .data_rdata_i(rd64),
    .lsu_req_i(req64), .lsu_we_i(we64), .lsu_type_i(ty64), .lsu_sign_ext_i(sx64),
    .lsu_addr_i(addr64), .lsu_wdata_i(wd64),
    .lsu_ready_o(rdy64), .lsu_rvalid_o(lrv64), .lsu_rdata_o(lrd64),
    .load_err_o(lerr64), .store_err_o(serr64), .busy_o(busy64)
  );

  typedef struct {
    logic        we;
    logic [1:0]  ty;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_lerr;
    logic        e_serr;
  } vec_t;

  vec_t vt [12];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One aligned access on the 32-bit bus: grant at once, respond the next cycle
  task automatic one32(input vec_t v, input string nm);
    @(negedge clk);
    rv32 = 0; er32 = 0; gnt32 = 1;
    req32 = 1; we32 = v.we; ty32 = v.ty; sx32 = v.sx; addr32 = v.addr; wd32 = v.wdata;
    #1;
    chk({nm, ".req"},   64'(dreq32),  64'd1);
    chk({nm, ".addr"},  64'(daddr32), 64'(v.e_addr));
    chk({nm, ".be"},    64'(dbe32),   64'(v.e_be));
    chk({nm, ".we"},    64'(dwe32),   64'(v.we));
    chk({nm, ".wdata"}, 64'(dwd32),   64'(v.e_wdata));
    chk({nm, ".ready"}, 64'(rdy32),   64'd1);
    @(negedge clk);
    req32 = 0; rv32 = 1; rd32 = v.rdata; er32 = v.err;
    #1;
    chk({nm, ".rvalid"}, 64'(lrv32),  64'd1);
    chk({nm, ".rdata"},  64'(lrd32),  64'(v.e_rdata));
    chk({nm, ".lerr"},   64'(lerr32), 64'(v.e_lerr));
    chk({nm, ".serr"},   64'(serr32), 64'(v.e_serr));
    @(negedge clk);
    rv32 = 0; er32 = 0;
  endtask

  task automatic run64(input logic we, input logic [1:0] ty, input logic sx, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [63:0] rd, input logic [31:0] e_addr,
                       input logic [7:0] e_be, input logic [63:0] e_wd, input logic [31:0] e_rd,
                       input string nm);
    @(negedge clk);
    rv64 = 0; gnt64 = 1; req64 = 1; we64 = we; ty64 = ty; sx64 = sx; addr64 = addr; wd64 = wd;
    #1;
    chk({nm, ".addr"},  64'(daddr64), 64'(e_addr));
    chk({nm, ".be"},    64'(dbe64),   64'(e_be));
    chk({nm, ".wdata"}, dwd64,        e_wd);
    @(negedge clk);
    req64 = 0; rv64 = 1; rd64 = rd;
    #1;
    chk({nm, ".rvalid"}, 64'(lrv64), 64'd1);
    chk({nm, ".rdata"},  64'(lrd64), 64'(e_rd));
    @(negedge clk);
    rv64 = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we ty    sx addr      wdata         rdata         err e_addr    e_be   e_wdata       e_rdata       le  se
    vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        32'h11223344, 1'b0, 32'h100, 4'hF, 32'h0,        32'h11223344, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h80010000, 1'b0, 32'h100, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h80010000, 1'b0, 32'h100, 4'hC, 32'h0,        32'h00008001, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'h12347FFF, 1'b0, 32'h100, 4'h3, 32'h0,        32'h00007FFF, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 2'b10, 1'b1, 32'h103, 32'h0,        32'h7F000000, 1'b0, 32'h100, 4'h8, 32'h0,        32'h0000007F, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h00009A00, 1'b0, 32'h100, 4'h2, 32'h0,        32'h0000009A, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 2'b10, 1'b1, 32'h101, 32'h0,        32'h00009A00, 1'b0, 32'h100, 4'h2, 32'h0,        32'hFFFFFF9A, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 2'b00, 1'b0, 32'h200, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h0000CAFE, 32'hFFFFFFFF, 1'b0, 32'h200, 4'hC, 32'hCAFE0000, 32'h0,        1'b0, 1'b0};
    vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h201, 32'h123456A5, 32'h0,        1'b0, 32'h200, 4'h2, 32'h3456A512, 32'h0,        1'b0, 1'b0};
    vt[10] = '{1'b0, 2'b00, 1'b0, 32'h10C, 32'h0,        32'hCAFEF00D, 1'b1, 32'h10C, 4'hF, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    vt[11] = '{1'b1, 2'b11, 1'b0, 32'h203, 32'h000000A5, 32'h0,        1'b1, 32'h200, 4'h8, 32'hA5000000, 32'h0,        1'b0, 1'b1};

    // Reset with the bus idle: every output low
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst32.ctl",   64'({dreq32, dwe32, rdy32, lrv32, lerr32, serr32, busy32}), 64'd0);
    chk("rst32.addr",  64'(daddr32), 64'd0);
    chk("rst32.be",    64'(dbe32),   64'd0);
    chk("rst32.wdata", 64'(dwd32),   64'd0);
    chk("rst32.rdata", 64'(lrd32),   64'd0);
    chk("rst64.ctl",   64'({dreq64, dwe64, rdy64, lrv64, lerr64, serr64, busy64}), 64'd0);
    chk("rst64.wdata", dwd64,        64'd0);
    chk("rst64.rdata", 64'(lrd64),   64'd0);

    for (int i = 0; i < 12; i++) one32(vt[i], $sformatf("vec%0d", i));

    // Back-to-back aligned loads, overlapping grant and response
    @(negedge clk);
    gnt32 = 1; req32 = 1; we32 = 0; ty32 = 2'b00; sx32 = 0; addr32 = 32'h100; wd32 = 0;
    #1 chk("b2b.req1", 64'(dreq32), 64'd1);
    @(negedge clk);
    addr32 = 32'h104; rv32 = 1; rd32 = 32'h11223344;
    #1;
    chk("b2b.rv1",   64'(lrv32),   64'd1);
    chk("b2b.rd1",   64'(lrd32),   64'h11223344);
    chk("b2b.req2",  64'(dreq32),  64'd1);
    chk("b2b.addr2", 64'(daddr32), 64'h104);
    @(negedge clk);
    req32 = 0; rd32 = 32'h55667788;
    #1;
    chk("b2b.rv2", 64'(lrv32), 64'd1);
    chk("b2b.rd2", 64'(lrd32), 64'h55667788);
    @(negedge clk);
    rv32 = 0;
    #1 chk("b2b.idle", 64'({busy32, lrv32}), 64'd0);

    // Full tracking FIFO with the first response carrying an error
    @(negedge clk);
    gnt32 = 1; req32 = 1; we32 = 1; ty32 = 2'b00; addr32 = 32'h300; wd32 = 32'h1;
    #1 chk("ff.req1", 64'(dreq32), 64'd1);
    @(negedge clk);
    addr32 = 32'h304;
    #1 chk("ff.req2", 64'(dreq32), 64'd1);
    @(negedge clk);
    addr32 = 32'h308;
    #1;
    chk("ff.hold1", 64'({dreq32, rdy32, busy32}), 64'b001);
    @(negedge clk);
    #1 chk("ff.hold2", 64'(dreq32), 64'd0);
    @(negedge clk);
    rv32 = 1; er32 = 1;
    #1;
    chk("ff.hold3", 64'(dreq32), 64'd0);
    chk("ff.resp1", 64'({lrv32, serr32, lerr32}), 64'b110);
    @(negedge clk);
    er32 = 0;
    #1;
    chk("ff.go",    64'({dreq32, rdy32}), 64'b11);
    chk("ff.addr3", 64'(daddr32), 64'h308);
    chk("ff.resp2", 64'({lrv32, serr32}), 64'b10);
    @(negedge clk);
    req32 = 0;
    #1 chk("ff.resp3", 64'({lrv32, serr32}), 64'b10);
    @(negedge clk);
    rv32 = 0;
    #1 chk("ff.idle", 64'(busy32), 64'd0);

    // Wide bus lane placement
    run64(1'b0, 2'b10, 1'b1, 32'h105, 32'h0, 64'h0000_F000_0000_0000, 32'h100, 8'h20, 64'h0, 32'hFFFFFFF0, "w64.lb");
    run64(1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 64'h8765_4321_0000_0000, 32'h100, 8'hF0, 64'h0, 32'h87654321, "w64.lw");
    run64(1'b1, 2'b01, 1'b0, 32'h10E, 32'h0000BEEF, 64'h0, 32'h108, 8'hC0, 64'hBEEF_0000_0000_0000, 32'h0, "w64.sh");

`ifdef LSU_MISALIGNED_EN
    // Misaligned word load split across two beats
    @(negedge clk);
    gnt32 = 1; req32 = 1; we32 = 0; ty32 = 2'b00; sx32 = 0; addr32 = 32'h103; wd32 = 0;
    #1;
    chk("mis.b1.addr",  64'(daddr32), 64'h100);
    chk("mis.b1.be",    64'(dbe32),   64'h8);
    chk("mis.b1.ready", 64'(rdy32),   64'd0);
    @(negedge clk);
    rv32 = 1; rd32 = 32'hAABBCCDD;
    #1;
    chk("mis.b2.addr",  64'(daddr32), 64'h104);
    chk("mis.b2.be",    64'(dbe32),   64'h7);
    chk("mis.b2.ready", 64'(rdy32),   64'd1);
    chk("mis.b1.norv",  64'(lrv32),   64'd0);
    @(negedge clk);
    req32 = 0; rd32 = 32'h00112233;
    #1;
    chk("mis.rv",   64'(lrv32), 64'd1);
    chk("mis.data", 64'(lrd32), 64'h112233AA);
    chk("mis.lerr", 64'(lerr32), 64'd0);
    @(negedge clk);
    rv32 = 0;

    // Misaligned signed halfword with an error on the first beat only
    @(negedge clk);
    req32 = 1; we32 = 0; ty32 = 2'b01; sx32 = 1; addr32 = 32'h103;
    #1 chk("mish.b1.be", 64'(dbe32), 64'h8);
    @(negedge clk);
    rv32 = 1; rd32 = 32'h34000000; er32 = 1;
    #1;
    chk("mish.b2.be", 64'(dbe32), 64'h1);
    chk("mish.norv",  64'(lrv32), 64'd0);
    @(negedge clk);
    req32 = 0; rd32 = 32'h00000081; er32 = 0;
    #1;
    chk("mish.rdata", 64'(lrd32),  64'hFFFF8134);
    chk("mish.lerr",  64'(lerr32), 64'd1);
    @(negedge clk);
    rv32 = 0;
    one32('{1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h00000001, 1'b0,
            32'h100, 4'hF, 32'h0, 32'h00000001, 1'b0, 1'b0}, "errq_clr");

    // Misaligned store: both beats carry the rotated word
    @(negedge clk);
    req32 = 1; we32 = 1; ty32 = 2'b00; sx32 = 0; addr32 = 32'h102; wd32 = 32'h11223344;
    #1;
    chk("miss.b1.be",    64'(dbe32), 64'hC);
    chk("miss.b1.wdata", 64'(dwd32), 64'h33441122);
    @(negedge clk);
    rv32 = 1; rd32 = 32'hFFFFFFFF;
    #1;
    chk("miss.b2.be",    64'(dbe32), 64'h3);
    chk("miss.b2.wdata", 64'(dwd32), 64'h33441122);
    @(negedge clk);
    req32 = 0;
    #1 chk("miss.resp", 64'({lrv32, lrd32, serr32}), 64'({1'b1, 32'h0, 1'b0}));
    @(negedge clk);
    rv32 = 0;

    // Reset while in the second-beat state, then a stale response
    @(negedge clk);
    req32 = 1; we32 = 0; ty32 = 2'b00; addr32 = 32'h103;
    @(negedge clk);
    rst = 1; req32 = 0; gnt32 = 0;
    #1 chk("rst2.in_second", 64'(dreq32), 64'd1);
    @(negedge clk);
    rst = 0;
    #1 chk("rst2.idle", 64'({dreq32, busy32}), 64'd0);
    @(negedge clk);
    rv32 = 1; rd32 = 32'h12345678;
    #1 chk("rst2.late", 64'(lrv32), 64'd0);
    @(negedge clk);
    rv32 = 0;
`else
    // Misaligned halfword load waits for an empty FIFO, then errors without a bus request
    @(negedge clk);
    gnt32 = 1; req32 = 1; we32 = 0; ty32 = 2'b00; sx32 = 0; addr32 = 32'h100; wd32 = 0;
    @(negedge clk);
    ty32 = 2'b01; sx32 = 1; addr32 = 32'h003;
    #1 chk("mis.wait", 64'({dreq32, rdy32, lrv32}), 64'd0);
    @(negedge clk);
    rv32 = 1; rd32 = 32'h0BADF00D;
    #1;
    chk("mis.prior", 64'({lrv32, lerr32, rdy32}), 64'b100);
    chk("mis.prior.data", 64'(lrd32), 64'h0BADF00D);
    @(negedge clk);
    rv32 = 0;
    #1;
    chk("mis.err",   64'({dreq32, rdy32, lrv32, lerr32, serr32}), 64'b01110);
    chk("mis.rdata", 64'(lrd32), 64'd0);
    @(negedge clk);
    req32 = 0;
    #1 chk("mis.once", 64'(lrv32), 64'd0);
    @(negedge clk);
    req32 = 1; we32 = 1; ty32 = 2'b00; addr32 = 32'h002; wd32 = 32'h1;
    #1 chk("miss.err", 64'({dreq32, rdy32, lrv32, lerr32, serr32}), 64'b01101);
    @(negedge clk);
    req32 = 0;

    // Reset with a beat outstanding, then a stale response
    @(negedge clk);
    req32 = 1; we32 = 0; addr32 = 32'h100;
    @(negedge clk);
    req32 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("rst2.idle", 64'({dreq32, busy32}), 64'd0);
    @(negedge clk);
    rv32 = 1; rd32 = 32'h12345678;
    #1 chk("rst2.late", 64'(lrv32), 64'd0);
    @(negedge clk);
    rv32 = 0;
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
